// File: rtl/dds_pkg.sv
// Shared widths, waveform encoding and pipeline latency for the DDS waveform generator.
// Also provides the elaboration-time quarter-wave sine table generator.
package dds_pkg;

    localparam int DDS_AW      = 10;
    localparam int DDS_PW      = 11;
    localparam int DDS_LATENCY = 3;
    localparam int ROM_AW      = 9;
    localparam int ROM_DW      = 9;

    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SAW  = 2'd2,
        WAVE_SQR  = 2'd3
    } wave_e;

    // pi in Q30; the table is built with integer-only Taylor evaluation so it stays a constant.
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(511 * sin(pi/2 * (a + 0.5) / 512))
    function automatic logic [ROM_DW-1:0] sin_q(input int a);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (PI_Q30 * longint'(2 * a + 1)) / 64'sd2048;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return ROM_DW'((64'sd511 * sum + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/dds_sin_rom.sv
// Quarter-wave sine magnitude table, 512 x 9, with a registered read.
// Contents are fixed at elaboration so the array maps onto ROM/LUT constants.
module dds_sin_rom
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [ROM_DW-1:0] o_mag
);

    logic [ROM_DW-1:0] w_tab [2**ROM_AW];

    for (genvar g = 0; g < 2**ROM_AW; g++) begin : g_tab
        localparam logic [ROM_DW-1:0] MAG = sin_q(g);
        assign w_tab[g] = MAG;
    end

    always_ff @(posedge clk) begin
        o_mag <= w_tab[i_addr];
    end

endmodule

// File: rtl/dds_wave_gen.sv
// Three-stage DDS waveform generator: phase index, table read, output select.
// Waveform changes are deferred to a phase wrap so a period is never split between modes.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int AW = DDS_AW,
    parameter int PW = DDS_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   phase_in,
    input  logic          phase_vld,
    input  logic [PW-1:0] P,
    input  logic [1:0]    wave_sel,
    input  logic          sel_load,
    output logic [AW-1:0] wave_out,
    output logic          wave_vld,
    output logic          sq_out
);

    wave_e         r_pend;
    wave_e         r_active;
    logic [PW-1:0] r_last_idx;
    logic          r_seen;

    logic          r1_vld;
    logic [PW-1:0] r1_idx;
    wave_e         r1_sel;

    logic          r2_vld;
    logic [PW-1:0] r2_idx;
    wave_e         r2_sel;

    logic [AW-1:0] r_wave_out;
    logic          r_wave_vld;
    logic          r_sq_out;

    logic [PW-1:0]     w_idx;
    logic              w_wrap;
    wave_e             w_sel_now;
    logic [ROM_AW-1:0] w_rom_addr;
    logic [ROM_DW-1:0] w_mag;
    logic [AW-1:0]     w_wave;

    assign w_idx  = phase_in[31 -: PW] + P;
    assign w_wrap = phase_vld && r_seen && (w_idx < r_last_idx);

    // Before the first sample, or on the wrapping sample, the pending mode takes effect.
    assign w_sel_now = (!r_seen || w_wrap) ? r_pend : r_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= WAVE_SINE;
            r_active   <= WAVE_SINE;
            r_last_idx <= '0;
            r_seen     <= 1'b0;
            r1_vld     <= 1'b0;
            r1_idx     <= '0;
            r1_sel     <= WAVE_SINE;
        end else begin
            if (sel_load) begin
                r_pend <= wave_e'(wave_sel);
            end
            r_active <= w_sel_now;
            r1_vld   <= phase_vld;
            if (phase_vld) begin
                r_last_idx <= w_idx;
                r_seen     <= 1'b1;
                r1_idx     <= w_idx;
                r1_sel     <= w_sel_now;
            end
        end
    end

    assign w_rom_addr = r1_idx[PW-2] ? ~r1_idx[ROM_AW-1:0] : r1_idx[ROM_AW-1:0];

    dds_sin_rom u_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_mag  (w_mag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_vld <= 1'b0;
            r2_idx <= '0;
            r2_sel <= WAVE_SINE;
        end else begin
            r2_vld <= r1_vld;
            r2_idx <= r1_idx;
            r2_sel <= r1_sel;
        end
    end

    always_comb begin
        w_wave = '0;
        unique case (r2_sel)
            WAVE_SINE: w_wave = r2_idx[PW-1] ? (AW'(511) - AW'(w_mag)) : (AW'(512) + AW'(w_mag));
            WAVE_TRI:  w_wave = r2_idx[PW-1] ? (AW'(1023) - r2_idx[AW-1:0]) : r2_idx[AW-1:0];
            WAVE_SAW:  w_wave = r2_idx[PW-1:1];
            WAVE_SQR:  w_wave = r2_idx[PW-1] ? '0 : '1;
            default:   w_wave = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wave_out <= '0;
            r_wave_vld <= 1'b0;
            r_sq_out   <= 1'b0;
        end else begin
            r_wave_vld <= r2_vld;
            r_sq_out   <= r2_vld & r2_idx[PW-1];
            if (r2_vld) begin
                r_wave_out <= w_wave;
            end
        end
    end

    assign wave_out = r_wave_out;
    assign wave_vld = r_wave_vld;
    assign sq_out   = r_sq_out;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: driver pushes model expectations, monitor pops on wave_vld.
// The model works from the waveform formulas directly, with the sine table built from $sin.
module tb_dds_wave_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] phase_in = '0;
    logic        phase_vld = 1'b0;
    logic [10:0] P = '0;
    logic [1:0]  wave_sel = '0;
    logic        sel_load = 1'b0;
    logic [9:0]  wave_out;
    logic        wave_vld;
    logic        sq_out;

    always #5 clk = ~clk;

    dds_wave_gen #(.AW(10), .PW(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .phase_in  (phase_in),
        .phase_vld (phase_vld),
        .P         (P),
        .wave_sel  (wave_sel),
        .sel_load  (sel_load),
        .wave_out  (wave_out),
        .wave_vld  (wave_vld),
        .sq_out    (sq_out)
    );

    typedef struct {
        int out;
        int sq;
        int stamp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   rom_m[512];

    int m_pend, m_active, m_last;
    bit m_seen;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int exp_wave(input int mode, input int idx);
        int qd, a, mag;
        case (mode)
            0: begin
                qd  = idx / 512;
                a   = idx % 512;
                mag = (qd % 2 == 1) ? rom_m[511 - a] : rom_m[a];
                return (qd >= 2) ? 511 - mag : 512 + mag;
            end
            1: return (idx >= 1024) ? 1023 - (idx - 1024) : idx;
            2: return idx / 2;
            default: return (idx >= 1024) ? 0 : 1023;
        endcase
    endfunction

    // One input cycle; the model decides which waveform the sample belongs to.
    task automatic drive(input bit vld, input logic [31:0] ph, input logic [10:0] p,
                         input logic [1:0] sel, input bit load);
        int idx;
        exp_t e;
        @(posedge clk);
        #1;
        phase_vld = vld;
        phase_in  = ph;
        P         = p;
        wave_sel  = sel;
        sel_load  = load;
        idx = (int'(ph[31:21]) + int'(p)) % 2048;
        if (vld) begin
            if (!m_seen || idx < m_last) m_active = m_pend;
            e.out   = exp_wave(m_active, idx);
            e.sq    = idx / 1024;
            e.stamp = cyc;
            q.push_back(e);
            m_last = idx;
            m_seen = 1'b1;
        end else if (!m_seen) begin
            m_active = m_pend;
        end
        if (load) m_pend = int'(sel);
    endtask

    task automatic samp(input int idx, input int p, input bit load, input int sel);
        drive(1'b1, 32'(idx) << 21, 11'(p), 2'(sel), load);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic load_sel(input int sel);
        drive(1'b0, '0, '0, 2'(sel), 1'b1);
    endtask

    task automatic do_reset();
        #2;
        rst       = 1'b1;
        phase_vld = 1'b0;
        sel_load  = 1'b0;
        #1;
        check("rst_wave_vld", int'(wave_vld), 0);
        check("rst_wave_out", int'(wave_out), 0);
        check("rst_sq_out", int'(sq_out), 0);
        q.delete();
        m_pend = 0; m_active = 0; m_last = 0; m_seen = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (wave_vld) begin
                check("sample_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("wave_out", int'(wave_out), e.out);
                    check("sq_out", int'(sq_out), e.sq);
                    check("latency", cyc - e.stamp, 3);
                end
            end else begin
                check("sq_idle", int'(sq_out), 0);
            end
        end
    end

    initial begin
        for (int a = 0; a < 512; a++)
            rom_m[a] = $rtoi(511.0 * $sin(3.14159265358979 * (real'(a) + 0.5) / 1024.0) + 0.5);
        m_pend = 0; m_active = 0; m_last = 0; m_seen = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("init_wave_vld", int'(wave_vld), 0);
        check("init_wave_out", int'(wave_out), 0);
        check("init_sq_out", int'(sq_out), 0);
        #1 rst = 1'b0;

        // square: phase 0 then half-turn
        load_sel(3);
        drive(1'b1, 32'h0000_0000, 11'd0, 2'd0, 1'b0);
        drive(1'b1, 32'h8000_0000, 11'd0, 2'd0, 1'b0);
        idle(5);

        // sine via phase offset
        do_reset();
        samp(0, 512, 1'b0, 0);
        samp(0, 1536, 1'b0, 0);
        idle(5);

        // sawtooth sweep, back to back
        do_reset();
        load_sel(2);
        for (int n = 0; n < 2048; n++) samp(n, 0, 1'b0, 0);
        idle(5);

        // triangle, square requested mid-period, takes effect at the wrap
        do_reset();
        load_sel(1);
        for (int i = 900; i < 2048; i += 4) samp(i, 0, i == 1000, 3);
        for (int i = 0; i < 40; i += 4) samp(i, 0, 1'b0, 0);
        idle(5);

        // bubbles
        samp(100, 0, 1'b0, 0);
        idle(1);
        samp(200, 0, 1'b0, 0);
        idle(2);
        samp(300, 0, 1'b0, 0);
        idle(5);

        // reset with three samples in flight, then mode must be back to sine
        do_reset();
        load_sel(3);
        samp(100, 0, 1'b0, 0);
        samp(200, 0, 1'b0, 0);
        samp(300, 0, 1'b0, 0);
        idle(1);
        check("vld_before_rst", int'(wave_vld), 1);
        do_reset();
        idle(4);
        samp(256, 0, 1'b0, 0);
        idle(5);

        // randomized traffic including wraps and strobes coinciding with wraps
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 11'($urandom_range(0, 2047)),
                  2'($urandom_range(0, 3)), $urandom_range(0, 11) == 0);
        end
        idle(6);

        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
